// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath-wide defaults shared by the register file, ALU, decoder
// and hazard unit so they all agree on widths and register-0 / bypass policy.
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_ADDR_W   = 5;
  localparam int CPU_NUM_RD   = 2;
  localparam int CPU_ZERO_REG = 1;
  localparam int CPU_BYPASS   = 1;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port of the register file.
// Selects the stored word, applies the hardwired-zero and write-bypass
// overrides, and derives the port's busy flag from the scoreboard.
// Ports:
//   raddr_i   - register addressed by this port
//   mem_i     - full storage array from the top
//   busy_i    - raw scoreboard from the top
//   wr_act_i  - a write that will land this cycle (already reset/mask gated)
//   waddr_i   - write address
//   wdata_i   - write data
//   rdata_o   - read data
//   rd_busy_o - register has a pending write not resolved by the bypass
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int ZERO_REG = CPU_ZERO_REG,
  parameter int BYPASS   = CPU_BYPASS,
  parameter int DEPTH    = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0]             raddr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic [DEPTH-1:0]              busy_i,
  input  logic                          wr_act_i,
  input  logic [ADDR_W-1:0]             waddr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rd_busy_o
);

  logic zero_hit;
  logic byp_hit;

  always_comb begin
    zero_hit  = (ZERO_REG != 0) && (raddr_i == '0);
    byp_hit   = (BYPASS != 0) && wr_act_i && (waddr_i == raddr_i);
    rdata_o   = mem_i[raddr_i];
    rd_busy_o = busy_i[raddr_i];
    // Zero register has priority: its write is masked, so no bypass can hit it.
    if (zero_hit) begin
      rdata_o   = '0;
      rd_busy_o = 1'b0;
    end else if (byp_hit) begin
      rdata_o   = wdata_i;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port general-purpose register file with
// write-to-read bypass, optional hardwired-zero r0 and a per-register busy
// scoreboard (set by decode reservation, cleared by writeback).
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   we/waddr/wdata    - writeback write port
//   raddr/rdata       - NUM_RD packed read ports (port i at slice i)
//   rd_busy           - per-port pending-write flag
//   rsv_valid/addr    - destination reservation from decode
//   busy_vec          - raw scoreboard
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_RD   = CPU_NUM_RD,
  parameter int ZERO_REG = CPU_ZERO_REG,
  parameter int BYPASS   = CPU_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic                         wr_act;
  logic                         rsv_act;

  // Gating with rst keeps the bypass from leaking wdata onto rdata in reset.
  assign wr_act  = rst && we && !((ZERO_REG != 0) && (waddr == '0));
  assign rsv_act = rst && rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_act) begin
      mem_d[waddr]  = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Applied after the clear: an older writeback and a newer reservation of
    // the same register in one cycle must leave it busy.
    if (rsv_act) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rdport
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .DEPTH    (DEPTH)
    ) u_rdport (
      .raddr_i   (raddr[i*ADDR_W +: ADDR_W]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
      .wr_act_i  (wr_act),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .rdata_o   (rdata[i*DATA_W +: DATA_W]),
      .rd_busy_o (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two register files from one stimulus stream:
//   dut_a - defaults (ZERO_REG=1, BYPASS=1)
//   dut_b - ZERO_REG=0, BYPASS=0
// Each is compared every cycle against an array-based model of the register
// file rules, with directed literal checks for the documented scenarios.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rdb_a, rdb_b;
  logic [31:0] bv_a, bv_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rd_busy(rdb_a),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy_vec(bv_a)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rd_busy(rdb_b),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy_vec(bv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: index 0 = dut_a, 1 = dut_b ----------
  logic [31:0] m_mem  [2][32];
  logic [31:0] m_busy [2];

  function automatic bit zr(int c); return c == 0; endfunction
  function automatic bit bp(int c); return c == 0; endfunction

  function automatic bit wr_live(int c);
    return rst && we && !(zr(c) && waddr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int c, logic [4:0] ra);
    if (!rst) return 32'd0;
    if (zr(c) && ra == 5'd0) return 32'd0;
    if (bp(c) && wr_live(c) && waddr == ra) return wdata;
    return m_mem[c][ra];
  endfunction

  function automatic logic exp_rb(int c, logic [4:0] ra);
    if (!rst) return 1'b0;
    if (zr(c) && ra == 5'd0) return 1'b0;
    if (bp(c) && wr_live(c) && waddr == ra) return 1'b0;
    return m_busy[c][ra];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_busy[c] = 32'd0;
        for (int r = 0; r < 32; r++) m_mem[c][r] = 32'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (wr_live(c)) begin
          m_mem[c][waddr]  = wdata;
          m_busy[c][waddr] = 1'b0;
        end
        if (rsv_valid && !(zr(c) && rsv_addr == 5'd0))
          m_busy[c][rsv_addr] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare, mid-cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rdata_a", rdata_a, {exp_rd(0, raddr[9:5]), exp_rd(0, raddr[4:0])});
      chk("cyc_rdbusy_a", rdb_a, {exp_rb(0, raddr[9:5]), exp_rb(0, raddr[4:0])});
      chk("cyc_busyvec_a", bv_a, m_busy[0]);
      chk("cyc_rdata_b", rdata_b, {exp_rd(1, raddr[9:5]), exp_rd(1, raddr[4:0])});
      chk("cyc_rdbusy_b", rdb_b, {exp_rb(1, raddr[9:5]), exp_rb(1, raddr[4:0])});
      chk("cyc_busyvec_b", bv_b, m_busy[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic rv, input logic [4:0] ra);
    we = w; waddr = wa; wdata = wd;
    raddr = {r1, r0};
    rsv_valid = rv; rsv_addr = ra;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset held across an edge with a write and a reservation pending.
    drv(1, 5, 32'hCAFEF00D, 5, 5, 1, 6);
    tick;
    chk("rst_rdata_a", rdata_a, 64'd0);
    chk("rst_busyvec_a", bv_a, 64'd0);
    chk("rst_rdbusy_a", rdb_a, 64'd0);
    chk("rst_rdata_b", rdata_b, 64'd0);
    #1 rst = 1'b1;
    drv(0, 0, 0, 5, 6, 0, 0);
    #1;
    chk("rst_nowrite_a", rdata_a, 64'd0);
    chk("rst_nowrite_b", rdata_b, 64'd0);
    chk("rst_norsv_b", bv_b, 64'd0);
    tick;

    // Mid-cycle reset clears storage and scoreboard without an edge.
    drv(1, 5, 32'hDEADBEEF, 5, 3, 1, 3);
    tick;
    drv(0, 0, 0, 5, 3, 0, 0);
    #1;
    chk("pre_rst_r5_a", rdata_a, 64'h00000000_DEADBEEF);
    chk("pre_rst_bv_a", bv_a, 64'h8);
    rst = 1'b0;
    #1;
    chk("async_rst_r5_a", rdata_a, 64'd0);
    chk("async_rst_bv_a", bv_a, 64'd0);
    chk("async_rst_r5_b", rdata_b, 64'd0);
    chk("async_rst_bv_b", bv_b, 64'd0);
    rst = 1'b1;
    tick;

    // Basic write then read.
    drv(1, 1, 32'h11111111, 0, 0, 0, 0);
    tick;
    drv(1, 31, 32'hFFFFFFFF, 0, 0, 0, 0);
    tick;
    drv(0, 0, 0, 1, 31, 0, 0);
    #1;
    chk("basic_a", rdata_a, 64'hFFFFFFFF_11111111);
    chk("basic_b", rdata_b, 64'hFFFFFFFF_11111111);
    drv(0, 0, 0, 2, 2, 0, 0);
    #1;
    chk("basic_r2_a", rdata_a, 64'd0);
    tick;

    // Register 0 write + reservation.
    drv(1, 0, 32'h12345678, 0, 0, 1, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zero_rdata_a", rdata_a, 64'd0);
    chk("zero_bv0_a", bv_a[0], 64'd0);
    chk("zero_rdbusy_a", rdb_a, 64'd0);
    chk("nozero_rdata_b", rdata_b, 64'h12345678_12345678);
    chk("nozero_bv0_b", bv_b[0], 64'd1);
    tick;

    // Bypass vs no bypass.
    drv(1, 7, 32'h01010101, 0, 0, 0, 0);
    tick;
    drv(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0);
    #1;
    chk("bypass_a", rdata_a, 64'hA5A5A5A5_A5A5A5A5);
    chk("nobypass_old_b", rdata_b, 64'h01010101_01010101);
    tick;
    drv(0, 0, 0, 7, 7, 0, 0);
    #1;
    chk("nobypass_new_b", rdata_b, 64'hA5A5A5A5_A5A5A5A5);
    tick;

    // Scoreboard set, then cleared by writeback.
    drv(0, 0, 0, 9, 9, 1, 9);
    tick;
    drv(0, 0, 0, 9, 9, 0, 0);
    #1;
    chk("sb_set_bv_a", bv_a[9], 64'd1);
    chk("sb_set_rdbusy_a", rdb_a, 64'd3);
    chk("sb_set_rdbusy_b", rdb_b, 64'd3);
    tick;
    drv(1, 9, 32'h99999999, 9, 9, 0, 0);
    #1;
    chk("sb_wb_rdbusy_a", rdb_a, 64'd0);
    chk("sb_wb_rdbusy_b", rdb_b, 64'd3);
    chk("sb_wb_bv_a", bv_a[9], 64'd1);
    tick;
    drv(0, 0, 0, 9, 9, 0, 0);
    #1;
    chk("sb_clr_bv_a", bv_a[9], 64'd0);
    chk("sb_clr_rdbusy_b", rdb_b, 64'd0);
    tick;

    // Set and clear of r4 in the same cycle.
    drv(0, 0, 0, 4, 4, 1, 4);
    tick;
    drv(1, 4, 32'h44444444, 4, 4, 1, 4);
    tick;
    drv(0, 0, 0, 4, 4, 0, 0);
    #1;
    chk("coll_bv_a", bv_a[4], 64'd1);
    chk("coll_bv_b", bv_b[4], 64'd1);
    chk("coll_data_a", rdata_a, 64'h44444444_44444444);
    chk("coll_rdbusy_a", rdb_a, 64'd3);
    chk("model_pin_r4", m_mem[0][4], 64'h44444444);
    chk("model_pin_r7", m_mem[1][7], 64'hA5A5A5A5);
    tick;

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 3000; n++) begin
      drv(1'($urandom_range(0, 1)), pick(), $urandom, pick(), pick(),
          ($urandom_range(0, 9) < 3), pick());
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      tick;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
